// File: rtl/pad_ctrl_pkg.sv
// Shared types and constants for the pad bank controller.
// Holds the FSM state encoding, drive-config reset values and counter widths.
package pad_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RECV  = 2'd1,
        ST_TURN  = 2'd2,
        ST_DRIVE = 2'd3
    } pad_state_e;

    localparam logic [1:0] DS_RESET = 2'b01;
    localparam logic       SR_RESET = 1'b0;

    // One counter serves both INIT (up to 255) and TURN (up to 15).
    localparam int INIT_CNT_W = 8;
    localparam int TURN_CNT_W = 4;
    localparam int CNT_W      = (INIT_CNT_W > TURN_CNT_W) ? INIT_CNT_W : TURN_CNT_W;

endpackage

// File: rtl/pad_turn_cnt.sv
// Loadable down-counter shared by the INIT settle and bus-turnaround phases.
// Load has priority over enable; the count saturates at zero.
module pad_turn_cnt
    import pad_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pad_bank_ctrl.sv
// Direction and drive-config controller for a bank of bidirectional pads.
// Every output is registered from the next state, so OE and IE can never overlap.
module pad_bank_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int NPADS    = 8,
    parameter int TURN_CYC = 2,
    parameter int INIT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir_valid,
    input  logic             dir_out,
    output logic             dir_ready,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_ds,
    input  logic             cfg_sr,
    output logic             cfg_ready,
    output logic [NPADS-1:0] pad_oe,
    output logic [NPADS-1:0] pad_ie,
    output logic             pad_ds0,
    output logic             pad_ds1,
    output logic             pad_sr,
    output logic             pad_rto,
    output logic             pad_sns,
    output logic             busy,
    output logic             cur_dir
);

    // The first INIT cycle is spent loading, hence the extra minus one.
    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYC - 2);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);

    pad_state_e       state;
    pad_state_e       next_state;
    logic             init_loaded;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt;
    logic             dir_fire;
    logic             cfg_fire;
    logic             init_last;
    logic             init_penult;

    assign dir_fire    = dir_valid & dir_ready;
    assign cfg_fire    = cfg_valid & cfg_ready;
    assign init_last   = init_loaded ? cnt_zero : (INIT_CYC == 1);
    assign init_penult = init_loaded ? (cnt == CNT_W'(1)) : (INIT_CYC == 2);

    pad_turn_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_en     = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_last) begin
                    next_state = ST_RECV;
                end else if (!init_loaded) begin
                    cnt_load = 1'b1;
                    cnt_val  = INIT_LOAD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_RECV, ST_DRIVE: begin
                if (dir_fire && (dir_out != cur_dir)) begin
                    next_state = ST_TURN;
                    cnt_load   = 1'b1;
                    cnt_val    = TURN_LOAD;
                end
            end
            ST_TURN: begin
                if (cnt_zero) begin
                    next_state = cur_dir ? ST_RECV : ST_DRIVE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: next_state = ST_INIT;
        endcase
    end

    // cur_dir follows only the settled states, so it holds its old value through TURN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            init_loaded <= 1'b0;
            pad_oe      <= '0;
            pad_ie      <= '0;
            pad_ds0     <= DS_RESET[0];
            pad_ds1     <= DS_RESET[1];
            pad_sr      <= SR_RESET;
            pad_rto     <= 1'b0;
            pad_sns     <= 1'b0;
            busy        <= 1'b1;
            cur_dir     <= 1'b0;
            dir_ready   <= 1'b0;
            cfg_ready   <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == ST_INIT) && cnt_load) begin
                init_loaded <= 1'b1;
            end
            pad_oe    <= (next_state == ST_DRIVE) ? {NPADS{1'b1}} : {NPADS{1'b0}};
            pad_ie    <= (next_state == ST_RECV)  ? {NPADS{1'b1}} : {NPADS{1'b0}};
            busy      <= (next_state == ST_INIT) || (next_state == ST_TURN);
            dir_ready <= (next_state == ST_RECV) || (next_state == ST_DRIVE);
            cfg_ready <= (next_state == ST_RECV) || (next_state == ST_DRIVE);
            if (next_state == ST_DRIVE) begin
                cur_dir <= 1'b1;
            end else if (next_state == ST_RECV) begin
                cur_dir <= 1'b0;
            end
            if ((state == ST_INIT) && (init_penult || init_last)) begin
                pad_rto <= 1'b1;
                pad_sns <= 1'b1;
            end
            if (cfg_fire) begin
                pad_ds0 <= cfg_ds[0];
                pad_ds1 <= cfg_ds[1];
                pad_sr  <= cfg_sr;
            end
        end
    end

endmodule

// File: doc/pad_bank_ctrl.md
PAD_BANK_CTRL -- requirements
Module: pad_bank_ctrl

Interface
REQ-001 Parameter NPADS, default 8, number of bidirectional pads in the bank.
REQ-002 Parameter TURN_CYC, default 2, bus-turnaround cycles with OE=0 and IE=0; legal range 1..15.
REQ-003 Parameter INIT_CYC, default 16, power-up settle cycles before the bank leaves INIT; legal range 1..255.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high. Ports are clk and rst.
REQ-005 clk  in  1  bank clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 dir_valid  in  1  direction request valid.
REQ-008 dir_out  in  1  requested direction: 1 = drive (output), 0 = receive (input).
REQ-009 dir_ready  out  1  direction request accepted when dir_valid and dir_ready are both high.
REQ-010 cfg_valid  in  1  drive-config request valid.
REQ-011 cfg_ds  in  2  drive strength {DS1,DS0}.
REQ-012 cfg_sr  in  1  slew-rate select.
REQ-013 cfg_ready  out  1  config accepted when cfg_valid and cfg_ready are both high.
REQ-014 pad_oe  out  NPADS  per-pad output enable.
REQ-015 pad_ie  out  NPADS  per-pad input enable.
REQ-016 pad_ds0, pad_ds1, pad_sr  out  1 each  shared drive controls.
REQ-017 pad_rto, pad_sns  out  1 each  shared retention/sense controls.
REQ-018 busy  out  1  high in INIT and TURN.
REQ-019 cur_dir  out  1  current settled direction (1 = drive).

Function
REQ-020 The FSM SHALL have four states: INIT, RECV, TURN, DRIVE.
REQ-021 INIT SHALL hold pad_oe=0 and pad_ie=0, count INIT_CYC cycles, assert pad_rto=1 and pad_sns=1 on the last INIT cycle, then enter RECV.
REQ-022 RECV SHALL drive pad_oe=0 and pad_ie=all-ones; DRIVE SHALL drive pad_oe=all-ones and pad_ie=0; TURN SHALL drive both 0.
REQ-023 dir_ready and cfg_ready SHALL be high only in RECV and DRIVE.
REQ-024 An accepted request with dir_out equal to cur_dir SHALL leave the state and all outputs unchanged.
REQ-025 An accepted request with dir_out different from cur_dir SHALL enter TURN on the next cycle, stay exactly TURN_CYC cycles, then enter the target state.
REQ-026 No cycle SHALL have any pad_oe bit and the same pad_ie bit both high.
REQ-027 OE SHALL never rise directly after IE: every direction change SHALL pass through TURN.
REQ-028 cur_dir SHALL update on entry to the target state, not on entry to TURN.
REQ-029 An accepted config SHALL update pad_ds0, pad_ds1 and pad_sr on the following cycle.
REQ-030 Simultaneous dir and cfg acceptance SHALL both take effect: the config applies next cycle, and the turnaround proceeds as normal.
REQ-031 Requests presented while not ready SHALL be held by the requester; the block SHALL NOT latch them.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 On rst high, asynchronously: state=INIT, counters=0, pad_oe=0, pad_ie=0, pad_ds0=1, pad_ds1=0, pad_sr=0, pad_rto=0, pad_sns=0, busy=1, cur_dir=0, dir_ready=0, cfg_ready=0.
REQ-034 Reset asserted mid-TURN or mid-DRIVE SHALL immediately force the reset values of REQ-033, and the bank SHALL re-run the full INIT sequence.

Structure
REQ-035 Package pad_ctrl_pkg SHALL hold the state enum, reset drive-config constants (DS default 2'b01, SR default 0) and counter width constants.
REQ-036 The down-counter used for INIT and TURN SHALL be one sub-module, pad_turn_cnt (load, enable, zero flag).
REQ-037 The target implementation size is 120-400 lines of RTL.

Verification
REQ-038 Reset release with INIT_CYC=16: busy=1, oe=0, ie=0 for 16 cycles; then ie=0xFF, rto=sns=1, busy=0, dir_ready=1.
REQ-039 In RECV, one-cycle dir_valid with dir_out=1: 2 cycles of oe=0/ie=0, then oe=0xFF, ie=0, cur_dir=1.
REQ-040 In DRIVE, dir_out=1 request: accepted, zero cycles of TURN, outputs unchanged.
REQ-041 cfg_ds=2'b11, cfg_sr=1 accepted in the same cycle as a direction change: ds0=ds1=sr=1 on the next cycle; TURN completes in TURN_CYC cycles.
REQ-042 rst pulse in the first TURN cycle: outputs hit reset values asynchronously, and INIT repeats for the full 16 cycles.
REQ-043 Random dir/cfg traffic, 10k cycles: an assertion checks oe&ie==0 every cycle, and the bench checks there is no dir/cfg acceptance while busy.
